// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control unit (FSM, ALU decode, immediate select)
//
// Purpose:
//   Sequences each instruction held in the instruction register through a
//   fixed per-opcode schedule of states and drives the datapath control
//   signals for every cycle. Supports lw, sw, R-type / I-type ALU
//   (add/sub/slt/or/and), beq and jal.
//
// Parameters:
//   TRAP_ON_ILLEGAL  1: unsupported op/funct3 parks the FSM in TRAP until rst
//                    0: unsupported op/funct3 behaves as a NOP (DECODE -> FETCH)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   op          in   [6:0] instruction[6:0]
//   funct3      in   [2:0] instruction[14:12]
//   funct7b5    in   instruction[30]
//   zero        in   ALU result == 0 (resolves beq)
//   PCWrite     out  PC enable = PCUpdate | (Branch & zero)
//   AdrSrc      out  memory address select: 0 PC, 1 ALUOut
//   MemWrite    out  data memory write enable
//   IRWrite     out  instruction register enable
//   ResultSrc   out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     out  [1:0] 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB     out  [1:0] 00 rs2, 01 ImmExt, 10 constant 4
//   RegWrite    out  register file write enable
//   ImmSrc      out  [1:0] 00 I, 01 S, 10 B, 11 J
//   ALUControl  out  [2:0] 000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal     out  high while in TRAP
//   state_o     out  [3:0] current state encoding

module multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state_o
);

    // State encoding is visible on state_o, so the codes are fixed.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state;
    logic [3:0] state_next;

    // Where an unsupported op/funct3 goes when leaving DECODE.
    logic [3:0] illegal_target;
    assign illegal_target = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    // Only add/sub, slt, or, and are implemented for R/I-type.
    logic funct3_ok;
    always_comb begin
        funct3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: funct3_ok = 1'b1;
            default:                        funct3_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = funct3_ok ? S_EXECUTER : illegal_target;
                    OP_I:         state_next = funct3_ok ? S_EXECUTEI : illegal_target;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = illegal_target;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;   // codes 12-15 recover
        endcase
    end

    // ------------------------------------------------------------------
    // Moore control decode (per-state schedule)
    // ------------------------------------------------------------------
    logic       pcupdate;
    logic       branch;
    logic       adrsrc_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic [1:0] resultsrc_s;
    logic [1:0] alusrca_s;
    logic [1:0] alusrcb_s;
    logic       regwrite_s;
    logic [1:0] aluop;
    logic       trap_s;

    always_comb begin
        pcupdate    = 1'b0;
        branch      = 1'b0;
        adrsrc_s    = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        resultsrc_s = 2'b00;
        alusrca_s   = 2'b00;
        alusrcb_s   = 2'b00;
        regwrite_s  = 1'b0;
        aluop       = ALUOP_ADD;
        trap_s      = 1'b0;
        case (state)
            S_FETCH: begin
                // PC + 4 computed and written back in the same cycle.
                irwrite_s   = 1'b1;
                alusrca_s   = 2'b00;
                alusrcb_s   = 2'b10;
                aluop       = ALUOP_ADD;
                resultsrc_s = 2'b10;
                pcupdate    = 1'b1;
            end
            S_DECODE: begin
                // OldPC + imm: branch target ready in ALUOut for BEQ.
                alusrca_s = 2'b01;
                alusrcb_s = 2'b01;
                aluop     = ALUOP_ADD;
            end
            S_MEMADR: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop     = ALUOP_ADD;
            end
            S_MEMREAD: begin
                resultsrc_s = 2'b00;
                adrsrc_s    = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_s = 2'b01;
                regwrite_s  = 1'b1;
            end
            S_MEMWRITE: begin
                resultsrc_s = 2'b00;
                adrsrc_s    = 1'b1;
                memwrite_s  = 1'b1;
            end
            S_EXECUTER: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b00;
                aluop     = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                alusrca_s = 2'b10;
                alusrcb_s = 2'b01;
                aluop     = ALUOP_FUNC;
            end
            S_ALUWB: begin
                resultsrc_s = 2'b00;
                regwrite_s  = 1'b1;
            end
            S_BEQ: begin
                // rs1 - rs2; PC takes ALUOut (target from DECODE) on zero.
                alusrca_s   = 2'b10;
                alusrcb_s   = 2'b00;
                aluop       = ALUOP_SUB;
                resultsrc_s = 2'b00;
                branch      = 1'b1;
            end
            S_JAL: begin
                // ALU forms the link value OldPC + 4 while PC loads the target.
                alusrca_s   = 2'b01;
                alusrcb_s   = 2'b10;
                aluop       = ALUOP_ADD;
                resultsrc_s = 2'b00;
                pcupdate    = 1'b1;
            end
            S_TRAP: begin
                trap_s = 1'b1;
            end
            default: begin
                trap_s = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    // Subtract only for R-type with funct7b5 set; an I-type addi whose
    // instr[30] happens to be 1 must still add.
    logic r_sub;
    assign r_sub = op[5] & funct7b5;

    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  ALUControl = r_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate format select (combinational from op)
    // ------------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    // State is already FETCH while rst is high, which would otherwise
    // present IRWrite/PCWrite; all write enables are gated by rst so no
    // write can fire during or straight after an aborting reset.
    assign PCWrite   = ~rst & (pcupdate | (branch & zero));
    assign IRWrite   = ~rst & irwrite_s;
    assign MemWrite  = ~rst & memwrite_s;
    assign RegWrite  = ~rst & regwrite_s;
    assign illegal   = ~rst & trap_s;

    assign AdrSrc    = adrsrc_s;
    assign ResultSrc = resultsrc_s;
    assign ALUSrcA   = alusrca_s;
    assign ALUSrcB   = alusrcb_s;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller (trap and nop variants)

module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pcw_t, adr_t, mw_t, irw_t, rw_t, ill_t;
    logic [1:0] rs_t, sa_t, sb_t, imm_t;
    logic [2:0] alu_t;
    logic [3:0] st_t;

    logic       pcw_n, adr_n, mw_n, irw_n, rw_n, ill_n;
    logic [1:0] rs_n, sa_n, sb_n, imm_n;
    logic [2:0] alu_n;
    logic [3:0] st_n;

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut_t (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw_t), .AdrSrc(adr_t), .MemWrite(mw_t), .IRWrite(irw_t),
        .ResultSrc(rs_t), .ALUSrcA(sa_t), .ALUSrcB(sb_t), .RegWrite(rw_t),
        .ImmSrc(imm_t), .ALUControl(alu_t), .illegal(ill_t), .state_o(st_t)
    );

    multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(pcw_n), .AdrSrc(adr_n), .MemWrite(mw_n), .IRWrite(irw_n),
        .ResultSrc(rs_n), .ALUSrcA(sa_n), .ALUSrcB(sb_n), .RegWrite(rw_n),
        .ImmSrc(imm_n), .ALUControl(alu_n), .illegal(ill_n), .state_o(st_n)
    );

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
    //  RegWrite, ImmSrc, ALUControl, illegal}
    logic [16:0] pack_t, pack_n;
    assign pack_t = {pcw_t, adr_t, mw_t, irw_t, rs_t, sa_t, sb_t, rw_t, imm_t, alu_t, ill_t};
    assign pack_n = {pcw_n, adr_n, mw_n, irw_n, rs_n, sa_n, sb_n, rw_n, imm_n, alu_n, ill_n};

    typedef struct {
        logic [3:0]  st_t;
        logic [16:0] o_t;
        logic [3:0]  st_n;
        logic [16:0] o_n;
    } item_t;

    item_t sbq[$];
    int    sq_t[$];
    int    sq_n[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference per-state outputs for a given immediate select, zero flag
    // and the ALU code expected in the EXECUTE states.
    function automatic logic [16:0] expect_out(input int s, input logic z,
                                               input logic [1:0] imm, input logic [2:0] exalu);
        logic       pc, adr, mw, ir, rw, il;
        logic [1:0] rs, sa, srcb;
        logic [2:0] alu;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0; il = 0;
        rs = 2'b00; sa = 2'b00; srcb = 2'b00; alu = 3'b000;
        case (s)
            0:  begin pc = 1; ir = 1; srcb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; srcb = 2'b01; end
            2:  begin sa = 2'b10; srcb = 2'b01; end
            3:  begin adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; alu = exalu; end
            7:  begin sa = 2'b10; srcb = 2'b01; alu = exalu; end
            8:  begin rw = 1; end
            9:  begin sa = 2'b10; alu = 3'b001; pc = z; end
            10: begin sa = 2'b01; srcb = 2'b10; pc = 1; end
            11: begin il = 1; end
            default: ;
        endcase
        return {pc, adr, mw, ir, rs, sa, srcb, rw, imm, alu, il};
    endfunction

    // Monitor: pops one expected entry per cycle, sampled at the falling edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            item_t it;
            it = sbq.pop_front();
            check("state_trap", {28'd0, st_t}, {28'd0, it.st_t});
            check("outs_trap",  {15'd0, pack_t}, {15'd0, it.o_t});
            check("state_nop",  {28'd0, st_n}, {28'd0, it.st_n});
            check("outs_nop",   {15'd0, pack_n}, {15'd0, it.o_n});
        end
    end

    // Called at posedge+1 at the start of a FETCH cycle; holds the
    // instruction fields for the length of the supplied state sequences.
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [1:0] imm, input logic [2:0] exalu);
        item_t it;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < sq_t.size(); i++) begin
            it.st_t = 4'(sq_t[i]);
            it.o_t  = expect_out(sq_t[i], z, imm, exalu);
            it.st_n = 4'(sq_n[i]);
            it.o_n  = expect_out(sq_n[i], z, imm, exalu);
            sbq.push_back(it);
        end
        repeat (sq_t.size()) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_state",  {28'd0, st_t}, 32'd0);
        check("rst_enable", {27'd0, pcw_t, irw_t, mw_t, rw_t, ill_t}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_state_n", {28'd0, st_n}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        #2;
        check("init_state",  {28'd0, st_t}, 32'd0);
        check("init_enable", {27'd0, pcw_t, irw_t, mw_t, rw_t, ill_t}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw
        sq_t = '{0, 1, 2, 3, 4}; sq_n = sq_t;
        run(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);
        // sw
        sq_t = '{0, 1, 2, 5}; sq_n = sq_t;
        run(7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000);
        // R-type sub / add / slt / and
        sq_t = '{0, 1, 6, 8}; sq_n = sq_t;
        run(7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001);
        run(7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000);
        run(7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101);
        run(7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010);
        // I-type addi with instr[30]=1 still adds; ori
        sq_t = '{0, 1, 7, 8}; sq_n = sq_t;
        run(7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000);
        run(7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011);
        // beq taken and not taken
        sq_t = '{0, 1, 9}; sq_n = sq_t;
        run(7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000);
        run(7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000);
        // jal
        sq_t = '{0, 1, 10, 8}; sq_n = sq_t;
        run(7'b1101111, 3'b000, 1'b0, 1'b1, 2'b11, 3'b000);

        // Reset in the middle of MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sw_memwrite_before", {31'd0, mw_t}, 32'd1);
        check("sw_state_before", {28'd0, st_t}, 32'd5);
        rst = 1'b1;
        #1;
        check("abort_memwrite", {31'd0, mw_t}, 32'd0);
        check("abort_state", {28'd0, st_t}, 32'd0);
        check("abort_enables", {28'd0, pcw_t, irw_t, rw_t, ill_t}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First fetch after release is a full fetch (IRWrite/PCWrite high)
        sq_t = '{0, 1, 2, 3, 4}; sq_n = sq_t;
        run(7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);

        // Illegal op: trap variant parks in TRAP, nop variant loops FETCH/DECODE
        sq_t.delete(); sq_n.delete();
        for (int i = 0; i < 24; i++) begin
            sq_t.push_back(i < 2 ? i : 11);
            sq_n.push_back(i % 2);
        end
        run(7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000);

        do_reset();
        // Unsupported R-type funct3 001
        sq_t = '{0, 1, 11, 11}; sq_n = '{0, 1, 0, 1};
        run(7'b0110011, 3'b001, 1'b0, 1'b0, 2'b00, 3'b000);

        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
